mem_test_initiator: RTL and testbench

MEM_TEST_INITIATOR -- requirements
Module: mem_test_initiator

---
 rtl/mem_test_pkg.sv | 38 +++
 rtl/mem_test_initiator_if.sv | 48 ++++
 rtl/mem_test_checker.sv | 107 ++++++++++
 rtl/mem_test_initiator.sv | 217 +++++++++++++++++++++
 tb/tb_mem_test_initiator.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_test_pkg.sv
// -----------------------------------------------------------------------------
// mem_test_pkg
// Shared types and constants for the memory test initiator slice:
//   op_e      - command opcode (FILL writes a pattern, CHECK reads and compares)
//   state_e   - initiator FSM states
//   DATA_W    - data bus width (32)
//   ERR_W     - width of the mismatch counter
//   BE_ALL    - byteenable with every lane active
//   next_pattern() - pattern step: seed+i when incrementing, seed otherwise
// -----------------------------------------------------------------------------
package mem_test_pkg;

   localparam int DATA_W = 32;
   localparam int ERR_W  = 14;

   localparam logic [3:0] BE_ALL  = 4'hF;
   localparam logic [3:0] BE_NONE = 4'h0;

   typedef enum logic {
      OP_FILL  = 1'b0,
      OP_CHECK = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Pattern word i+1 from word i; wraps modulo 2^32 by construction.
   function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] pat,
                                                      input logic              incr);
      next_pattern = pat + {{(DATA_W-1){1'b0}}, incr};
   endfunction

endpackage

// File: rtl/mem_test_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_test_initiator_if
// Avalon-MM style bus between the test initiator and a target data memory
// that has no waitrequest and a fixed read latency of one cycle.
//   address    [ADDR_W]  word address
//   byteenable [4]       lane enables
//   chipselect           access strobe
//   write                1 = write access, 0 = read access
//   writedata  [32]      write data
//   clken                target clock enable (high while the initiator is busy)
//   readdata   [32]      read data, valid the cycle after a read access
// Modports: master (initiator side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_test_initiator_if
   import mem_test_pkg::*;
#(
   parameter int ADDR_W = 13
) ();

   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              chipselect;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              clken;
   logic [DATA_W-1:0] readdata;

   modport master (
      output address,
      output byteenable,
      output chipselect,
      output write,
      output writedata,
      output clken,
      input  readdata
   );

   modport slave (
      input  address,
      input  byteenable,
      input  chipselect,
      input  write,
      input  writedata,
      input  clken,
      output readdata
   );

endinterface

// File: rtl/mem_test_checker.sv
// -----------------------------------------------------------------------------
// mem_test_checker
// One-cycle compare stage for CHECK commands. A read issued in cycle k has its
// expected word and address captured at the end of cycle k; readdata arrives
// in cycle k+1 and is compared there, the result landing at the end of k+1.
// Optional feature macro: MEM_TEST_CHECKSUM_EN adds a running 32-bit sum of
// every word read.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   clear           start sampled in IDLE: clears counters and checksum
//   rd_issue        a read access is on the bus this cycle
//   rd_addr/rd_exp  address and expected word of that read
//   readdata        memory read data (one cycle latency)
//   err_cnt         saturating mismatch count
//   first_err_addr  address of the first mismatch since clear
//   checksum        (MEM_TEST_CHECKSUM_EN only) sum of all words read
// -----------------------------------------------------------------------------
module mem_test_checker
   import mem_test_pkg::*;
#(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              rd_issue,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_exp,
   input  logic [DATA_W-1:0] readdata,
   output logic [ERR_W-1:0]  err_cnt,
`ifdef MEM_TEST_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
   localparam logic [ERR_W-1:0]  ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   logic              pend_r;
   logic [DATA_W-1:0] exp_r;
   logic [ADDR_W-1:0] pend_addr_r;
   logic [ERR_W-1:0]  err_cnt_r;
   logic [ADDR_W-1:0] first_err_r;
   logic              mismatch_s;

   // Mismatch only exists in the cycle carrying read data for a pending read.
   always_comb begin
      if (pend_r && (readdata != exp_r)) begin
         mismatch_s = 1'b1;
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Expected-data pipeline plus error counter and first-error address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_r      <= 1'b0;
         exp_r       <= {DATA_W{1'b0}};
         pend_addr_r <= ADDR_ZERO;
         err_cnt_r   <= ERR_ZERO;
         first_err_r <= ADDR_ZERO;
      end else begin
         pend_r <= rd_issue;
         if (rd_issue) begin
            exp_r       <= rd_exp;
            pend_addr_r <= rd_addr;
         end
         if (clear) begin
            err_cnt_r   <= ERR_ZERO;
            first_err_r <= ADDR_ZERO;
         end else if (mismatch_s) begin
            // Saturate rather than wrap so a huge error run never reads as clean.
            if (err_cnt_r != ERR_MAX) begin
               err_cnt_r <= err_cnt_r + ERR_ONE;
            end
            if (err_cnt_r == ERR_ZERO) begin
               first_err_r <= pend_addr_r;
            end
         end
      end
   end

   assign err_cnt        = err_cnt_r;
   assign first_err_addr = first_err_r;

`ifdef MEM_TEST_CHECKSUM_EN
   logic [DATA_W-1:0] sum_r;

   // Running sum of every word returned by a CHECK read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_r <= {DATA_W{1'b0}};
      end else if (clear) begin
         sum_r <= {DATA_W{1'b0}};
      end else if (pend_r) begin
         sum_r <= sum_r + readdata;
      end
   end

   assign checksum = sum_r;
`endif

endmodule

// File: rtl/mem_test_initiator.sv
// -----------------------------------------------------------------------------
// mem_test_initiator
// Memory test master. A start strobe in IDLE launches FILL (write a pattern)
// or CHECK (read back and compare) over len words beginning at base. One
// access is issued per cycle; the pattern is seed+i (incr=1) or seed (incr=0).
// Optional feature macro: MEM_TEST_CHECKSUM_EN adds the checksum output.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, op, base, len,   command strobe and arguments
//   seed, incr
//   abort                   stop the running command
//   busy, done              busy in WRITE/READ/DRAIN, one-cycle done pulse
//   cmd_err, aborted        command rejected / command was aborted
//   err_cnt, first_err_addr CHECK mismatch count and first mismatch address
//   checksum                (MEM_TEST_CHECKSUM_EN only) sum of words read
//   mem                     Avalon-MM master bus to the target memory
// -----------------------------------------------------------------------------
module mem_test_initiator
   import mem_test_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DEPTH  = 6144
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                op,
   input  logic [ADDR_W-1:0]   base,
   input  logic [ADDR_W:0]     len,
   input  logic [DATA_W-1:0]   seed,
   input  logic                incr,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                cmd_err,
   output logic                aborted,
   output logic [ERR_W-1:0]    err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr,
`ifdef MEM_TEST_CHECKSUM_EN
   output logic [DATA_W-1:0]   checksum,
`endif
   mem_test_initiator_if.master mem
);

   localparam logic [ADDR_W+1:0] DEPTH_L   = (ADDR_W+2)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   state_e            state_r;
   logic [ADDR_W:0]   cnt_r;      // accesses still to issue after the current one
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] pat_r;      // pattern word of the access on the bus
   logic [DATA_W-1:0] wdata_r;
   logic              cs_r;
   logic              wr_r;
   logic [3:0]        be_r;
   logic              busy_r;
   logic              clken_r;
   logic              done_r;
   logic              cmd_err_r;
   logic              aborted_r;
   logic              incr_r;

   op_e               op_s;
   logic [ADDR_W+1:0] end_s;
   logic              cmd_bad_s;
   logic              accept_s;
   logic              rd_issue_s;
   logic [DATA_W-1:0] pat_next_s;

   // Command validation and next-pattern arithmetic.
   always_comb begin
      op_s       = op_e'(op);
      end_s      = {2'b00, base} + {1'b0, len};
      pat_next_s = next_pattern(pat_r, incr_r);
      rd_issue_s = cs_r & ~wr_r;
      if ((len == LEN_ZERO) || (end_s > DEPTH_L)) begin
         cmd_bad_s = 1'b1;
      end else begin
         cmd_bad_s = 1'b0;
      end
      if (start && (state_r == ST_IDLE)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Command FSM; every bus and status output is a register of this block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= LEN_ZERO;
         addr_r    <= ADDR_ZERO;
         pat_r     <= DATA_ZERO;
         wdata_r   <= DATA_ZERO;
         cs_r      <= 1'b0;
         wr_r      <= 1'b0;
         be_r      <= BE_NONE;
         busy_r    <= 1'b0;
         clken_r   <= 1'b0;
         done_r    <= 1'b0;
         cmd_err_r <= 1'b0;
         aborted_r <= 1'b0;
         incr_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Abort is meaningless here; a simultaneous start wins.
               if (accept_s) begin
                  aborted_r <= 1'b0;
                  incr_r    <= incr;
                  if (cmd_bad_s) begin
                     state_r   <= ST_DONE;
                     done_r    <= 1'b1;
                     cmd_err_r <= 1'b1;
                  end else begin
                     cmd_err_r <= 1'b0;
                     busy_r    <= 1'b1;
                     clken_r   <= 1'b1;
                     cs_r      <= 1'b1;
                     be_r      <= BE_ALL;
                     addr_r    <= base;
                     pat_r     <= seed;
                     cnt_r     <= len - LEN_ONE;
                     if (op_s == OP_FILL) begin
                        state_r <= ST_WRITE;
                        wr_r    <= 1'b1;
                        wdata_r <= seed;
                     end else begin
                        state_r <= ST_READ;
                        wr_r    <= 1'b0;
                        wdata_r <= DATA_ZERO;
                     end
                  end
               end
            end
            ST_WRITE, ST_READ: begin
               if (abort || (cnt_r == LEN_ZERO)) begin
                  // Bus goes quiet next cycle; reads still drain their last word.
                  cs_r      <= 1'b0;
                  wr_r      <= 1'b0;
                  be_r      <= BE_NONE;
                  wdata_r   <= DATA_ZERO;
                  aborted_r <= abort;
                  if (state_r == ST_WRITE) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                     clken_r <= 1'b0;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else begin
                  cnt_r  <= cnt_r - LEN_ONE;
                  addr_r <= addr_r + ADDR_ONE;
                  pat_r  <= pat_next_s;
                  if (wr_r) begin
                     wdata_r <= pat_next_s;
                  end
               end
            end
            ST_DRAIN: begin
               state_r <= ST_DONE;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               clken_r <= 1'b0;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cs_r    <= 1'b0;
               wr_r    <= 1'b0;
               be_r    <= BE_NONE;
               busy_r  <= 1'b0;
               clken_r <= 1'b0;
            end
         endcase
      end
   end

   mem_test_checker #(
      .ADDR_W (ADDR_W)
   ) u_checker (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (accept_s),
      .rd_issue       (rd_issue_s),
      .rd_addr        (addr_r),
      .rd_exp         (pat_r),
      .readdata       (mem.readdata),
      .err_cnt        (err_cnt),
`ifdef MEM_TEST_CHECKSUM_EN
      .checksum       (checksum),
`endif
      .first_err_addr (first_err_addr)
   );

   assign mem.address    = addr_r;
   assign mem.byteenable = be_r;
   assign mem.chipselect = cs_r;
   assign mem.write      = wr_r;
   assign mem.writedata  = wdata_r;
   assign mem.clken      = clken_r;

   assign busy    = busy_r;
   assign done    = done_r;
   assign cmd_err = cmd_err_r;
   assign aborted = aborted_r;

endmodule

// File: tb/tb_mem_test_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_test_initiator
// Scoreboard bench: each command pushes its expected bus accesses and its
// expected done record; a negedge monitor pops and compares them as the DUT
// presents accesses and done pulses. A one-cycle-latency memory model sits
// on the slave side and can corrupt one address on reads.
// Optional feature macro: MEM_TEST_CHECKSUM_EN also checks the checksum.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_test_initiator;
   import mem_test_pkg::*;

   localparam int ADDR_W = 13;
   localparam int DEPTH  = 6144;

   typedef struct {
      int          cyc;
      logic [12:0] addr;
      logic        wr;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      int          cyc;
      logic        ce;
      logic        ab;
      logic [13:0] ec;
      logic [12:0] fa;
      logic [31:0] sum;
   } done_t;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        op      = 1'b0;
   logic        incr    = 1'b0;
   logic        abort   = 1'b0;
   logic [12:0] base    = 13'd0;
   logic [13:0] len     = 14'd0;
   logic [31:0] seed    = 32'h0;
   logic        busy, done, cmd_err, aborted;
   logic [13:0] err_cnt;
   logic [12:0] first_err_addr;
`ifdef MEM_TEST_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   mem_test_initiator_if #(.ADDR_W(ADDR_W)) bus ();

   mem_test_initiator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .op             (op),
      .base           (base),
      .len            (len),
      .seed           (seed),
      .incr           (incr),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .cmd_err        (cmd_err),
      .aborted        (aborted),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr),
`ifdef MEM_TEST_CHECKSUM_EN
      .checksum       (checksum),
`endif
      .mem            (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: one-cycle read latency, optional single-address corruption.
   logic [31:0] tmem [0:DEPTH-1];
   logic        corrupt_en   = 1'b0;
   logic [12:0] corrupt_addr = 13'd0;
   always @(posedge clk) begin
      if (bus.chipselect && bus.write && (int'(bus.address) < DEPTH))
         tmem[bus.address] <= bus.writedata;
      if (bus.chipselect && !bus.write && (int'(bus.address) < DEPTH))
         bus.readdata <= tmem[bus.address] ^
                         ((corrupt_en && (bus.address == corrupt_addr)) ? 32'h1 : 32'h0);
      else
         bus.readdata <= 32'h0;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0h, want nothing (cycle %0d)", name, act, cyc);
   endtask

   acc_t  acc_q[$];
   done_t done_q[$];
   int    done_count = 0;

   // Monitor: compares each access and each done pulse with the scoreboard.
   always @(negedge clk) begin
      if (reset_n) begin
         check("clken_eq_busy", 64'(bus.clken), 64'(busy));
         if (bus.chipselect) begin
            if (acc_q.size() == 0) begin
               flag("unexpected_access", 64'(bus.address));
            end else begin
               acc_t a;
               a = acc_q.pop_front();
               check("acc_cycle", 64'(cyc), 64'(a.cyc));
               check("acc_addr", 64'(bus.address), 64'(a.addr));
               check("acc_write", 64'(bus.write), 64'(a.wr));
               check("acc_be", 64'(bus.byteenable), 64'(4'hF));
               if (a.wr) check("acc_wdata", 64'(bus.writedata), 64'(a.data));
            end
         end else begin
            check("idle_write", 64'(bus.write), 64'(0));
            check("idle_be", 64'(bus.byteenable), 64'(0));
         end
         if (done) begin
            done_count++;
            if (done_q.size() == 0) begin
               flag("unexpected_done", 64'(cyc));
            end else begin
               done_t d;
               d = done_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(d.cyc));
               check("cmd_err", 64'(cmd_err), 64'(d.ce));
               check("aborted", 64'(aborted), 64'(d.ab));
               check("err_cnt", 64'(err_cnt), 64'(d.ec));
               check("first_err_addr", 64'(first_err_addr), 64'(d.fa));
               check("busy_in_done", 64'(busy), 64'(0));
`ifdef MEM_TEST_CHECKSUM_EN
               check("checksum", 64'(checksum), 64'(d.sum));
`endif
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_cs"}, 64'(bus.chipselect), 64'(0));
      check({tag, "_write"}, 64'(bus.write), 64'(0));
      check({tag, "_clken"}, 64'(bus.clken), 64'(0));
      check({tag, "_addr"}, 64'(bus.address), 64'(0));
      check({tag, "_wdata"}, 64'(bus.writedata), 64'(0));
      check({tag, "_be"}, 64'(bus.byteenable), 64'(0));
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
      check({tag, "_first"}, 64'(first_err_addr), 64'(0));
      check({tag, "_cmd_err"}, 64'(cmd_err), 64'(0));
      check({tag, "_aborted"}, 64'(aborted), 64'(0));
`ifdef MEM_TEST_CHECKSUM_EN
      check({tag, "_checksum"}, 64'(checksum), 64'(0));
`endif
   endtask

   // abort_at/extra_start_at: cycle offset from T (-1 = never, 0 = with start).
   task automatic run_cmd(input logic o, input int b, input int l, input logic [31:0] sd,
                          input logic inc, input int abort_at, input int extra_start_at,
                          input logic e_ce, input logic e_ab, input int e_err,
                          input int e_first, input logic [31:0] e_sum);
      int t, n, dc, budget;
      acc_t a;
      done_t d;
      @(posedge clk); #1;
      t = cyc;
      n = e_ce ? 0 : (((abort_at >= 1) && (abort_at < l)) ? abort_at : l);
      for (int i = 0; i < n; i++) begin
         a.cyc  = t + 1 + i;
         a.addr = 13'(b + i);
         a.wr   = (o == 1'b0);
         a.data = sd + (inc ? 32'(i) : 32'h0);
         acc_q.push_back(a);
      end
      d.cyc = e_ce ? t + 1 : (o ? t + n + 2 : t + n + 1);
      d.ce  = e_ce;
      d.ab  = e_ab;
      d.ec  = 14'(e_err);
      d.fa  = 13'(e_first);
      d.sum = e_sum;
      done_q.push_back(d);
      dc    = done_count;
      op    = o;
      base  = 13'(b);
      len   = 14'(l);
      seed  = sd;
      incr  = inc;
      start = 1'b1;
      abort = (abort_at == 0);
      budget = 0;
      while ((done_count == dc) && (budget < l + 20)) begin
         @(posedge clk); #1;
         budget++;
         start = (budget == extra_start_at);
         abort = (budget == abort_at);
      end
      start = 1'b0;
      abort = 1'b0;
      if (done_count == dc) flag("done_timeout", 64'(budget));
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int t, dc;
      acc_t a;
      for (int i = 0; i < DEPTH; i++) tmem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      //      op    base  len  seed          inc  ab  xs  ce    ab    err first sum
      run_cmd(1'b0, 0,    4,   32'h100,      1'b1, -1, -1, 1'b0, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b1, 0,    4,   32'h100,      1'b1, -1, -1, 1'b0, 1'b0, 0, 0,   32'h406);
      corrupt_en = 1'b1; corrupt_addr = 13'd2;
      run_cmd(1'b1, 0,    4,   32'h100,      1'b1, -1, -1, 1'b0, 1'b0, 1, 2,   32'h407);
      corrupt_en = 1'b0;
      run_cmd(1'b0, 6140, 5,   32'h11,       1'b1, -1, -1, 1'b1, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b0, 6143, 1,   32'hDEADBEEF, 1'b0, -1,  2, 1'b0, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b1, 6143, 1,   32'hDEADBEEF, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0,   32'hDEADBEEF);
      run_cmd(1'b1, 0,    0,   32'h0,        1'b1, -1, -1, 1'b1, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b0, 100,  100, 32'hA0000000, 1'b1, -1,  5, 1'b0, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b1, 100,  100, 32'hA0000000, 1'b1, 10, -1, 1'b0, 1'b1, 0, 0,   32'h4000002D);
      run_cmd(1'b0, 200,  6,   32'h55,       1'b0,  3, -1, 1'b0, 1'b1, 0, 0,   32'h0);
      run_cmd(1'b1, 200,  3,   32'h55,       1'b0, -1, -1, 1'b0, 1'b0, 0, 0,   32'hFF);
      run_cmd(1'b0, 300,  3,   32'h7,        1'b1,  0, -1, 1'b0, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b1, 300,  3,   32'h7,        1'b1, -1, -1, 1'b0, 1'b0, 0, 0,   32'h18);
      run_cmd(1'b1, 100,  5,   32'hA0000000, 1'b0, -1, -1, 1'b0, 1'b0, 4, 101, 32'h2000000A);

      // Reset in the middle of a FILL: two accesses, then silence and no done.
      @(posedge clk); #1;
      t = cyc;
      for (int i = 0; i < 2; i++) begin
         a.cyc = t + 1 + i; a.addr = 13'(i); a.wr = 1'b1; a.data = 32'h1000 + 32'(i);
         acc_q.push_back(a);
      end
      dc = done_count;
      op = 1'b0; base = 13'd0; len = 14'd8; seed = 32'h1000; incr = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_reset", 64'(done_count), 64'(dc));
      check("accesses_before_reset", 64'(acc_q.size()), 64'(0));
      reset_n = 1'b1;
      run_cmd(1'b0, 0,    4,   32'h200,      1'b1, -1, -1, 1'b0, 1'b0, 0, 0,   32'h0);
      run_cmd(1'b1, 0,    4,   32'h200,      1'b1, -1, -1, 1'b0, 1'b0, 0, 0,   32'h806);

      check("acc_queue_drained", 64'(acc_q.size()), 64'(0));
      check("done_queue_drained", 64'(done_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
